// File: rtl/cgra_exec_ctrl_pkg.sv
// Shared types and defaults for the CGRA run sequencer: FSM state encoding,
// run-mode encodings and the PE finish lag used as the default drain length.
package cgra_exec_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_EXEC  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } ctrl_state_t;

   localparam logic MODE32 = 1'b0;
   localparam logic MODE64 = 1'b1;

   // Cycles from the last context step until PE outputs settle.
   localparam int PE_FINISH_LAG = 9;

endpackage

// File: rtl/cgra_perf_cnt.sv
// Saturating 32-bit event counter with synchronous clear (clear wins over enable).
module cgra_perf_cnt (
   input  logic        CLK,
   input  logic        RST,
   input  logic        clr,
   input  logic        en,
   output logic [31:0] cnt
);

   logic [31:0] cnt_reg;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cnt_reg <= '0;
      end else if (clr) begin
         cnt_reg <= '0;
      end else if (en && (cnt_reg != 32'hFFFF_FFFF)) begin
         cnt_reg <= cnt_reg + 32'd1;
      end
   end

   assign cnt = cnt_reg;

endmodule

// File: rtl/cgra_exec_ctrl.sv
// Run sequencer for the PE array: broadcasts host context writes, issues start,
// walks the context steps with stall gating and waits out the PE drain before done.
// Optional performance counters are built when CGRA_CTRL_PERF_EN is defined.
module cgra_exec_ctrl
   import cgra_exec_ctrl_pkg::*;
#(
   parameter int PE_NUM_BITS   = 4,
   parameter int CTX_ADDR_BITS = 5,
   parameter int CTX_PE_BITS   = 32,
   parameter int CTX_IM_BITS   = 32,
   parameter int DRAIN_CYCLES  = PE_FINISH_LAG
) (
   input  logic                               CLK,
   input  logic                               RST,
   input  logic                               cfg_valid_in,
   output logic                               cfg_ready_out,
   input  logic                               cfg_sel_in,
   input  logic [PE_NUM_BITS+CTX_ADDR_BITS-1:0] cfg_addr_in,
   input  logic [31:0]                        cfg_data_in,
   input  logic                               run_req_in,
   input  logic                               run_mode_in,
   input  logic [CTX_ADDR_BITS-1:0]           run_len_in,
   input  logic                               stall_in,
   output logic                               busy_out,
   output logic                               done_out,
   output logic                               start_out,
   output logic                               Mode_out,
   output logic                               CTX_incr_out,
   output logic [PE_NUM_BITS+CTX_ADDR_BITS-1:0] CTX_PE_addra_out,
   output logic [CTX_PE_BITS-1:0]             CTX_PE_dina_out,
   output logic                               CTX_PE_ena_out,
   output logic                               CTX_PE_wea_out,
   output logic [PE_NUM_BITS+CTX_ADDR_BITS-1:0] CTX_IM_addra_out,
   output logic [CTX_IM_BITS-1:0]             CTX_IM_dina_out,
   output logic                               CTX_IM_ena_out,
   output logic                               CTX_IM_wea_out,
   output logic [31:0]                        cycle_cnt_out,
   output logic [31:0]                        stall_cnt_out
);

   localparam int CFG_ADDR_BITS = PE_NUM_BITS + CTX_ADDR_BITS;
   localparam int DRAIN_W       = $clog2(DRAIN_CYCLES + 1);

   ctrl_state_t              state_reg, state_next;
   logic [CTX_ADDR_BITS-1:0] step_reg, step_next;
   logic [CTX_ADDR_BITS-1:0] len_reg, len_next;
   logic [DRAIN_W-1:0]       drain_reg, drain_next;
   logic                     mode_reg, mode_next;
   logic                     ready_reg;
   logic                     cfg_fire;
   logic                     run_accept;

   logic [CFG_ADDR_BITS-1:0] pe_addr_reg, im_addr_reg;
   logic [CTX_PE_BITS-1:0]   pe_din_reg;
   logic [CTX_IM_BITS-1:0]   im_din_reg;
   logic                     pe_en_reg, im_en_reg;

   // ready is registered so it reads 0 while RST is held; it is 1 only in IDLE.
   assign cfg_fire   = cfg_valid_in & ready_reg;
   assign run_accept = run_req_in & ready_reg & ~cfg_valid_in;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_reg <= ST_IDLE;
         step_reg  <= '0;
         len_reg   <= '0;
         drain_reg <= '0;
         mode_reg  <= 1'b0;
         ready_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         step_reg  <= step_next;
         len_reg   <= len_next;
         drain_reg <= drain_next;
         mode_reg  <= mode_next;
         ready_reg <= (state_next == ST_IDLE);
      end
   end

   always_comb begin
      state_next   = state_reg;
      step_next    = step_reg;
      len_next     = len_reg;
      drain_next   = drain_reg;
      mode_next    = mode_reg;
      start_out    = 1'b0;
      busy_out     = 1'b0;
      done_out     = 1'b0;
      CTX_incr_out = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (run_accept) begin
               mode_next  = run_mode_in;
               len_next   = run_len_in;
               step_next  = '0;
               state_next = ST_START;
            end
         end
         ST_START: begin
            start_out  = 1'b1;
            busy_out   = 1'b1;
            drain_next = '0;
            state_next = ST_EXEC;
         end
         ST_EXEC: begin
            busy_out     = 1'b1;
            CTX_incr_out = ~stall_in;
            // Compare before incrementing so run_len = all-ones never wraps.
            if (!stall_in) begin
               if (step_reg == len_reg) begin
                  state_next = ST_DRAIN;
               end else begin
                  step_next = step_reg + 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            busy_out = 1'b1;
            if (drain_reg == DRAIN_W'(DRAIN_CYCLES - 1)) begin
               state_next = ST_DONE;
            end else begin
               drain_next = drain_reg + 1'b1;
            end
         end
         ST_DONE: begin
            done_out   = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Context writes are broadcast; each PE decodes its own index from the address.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         pe_addr_reg <= '0;
         pe_din_reg  <= '0;
         pe_en_reg   <= 1'b0;
         im_addr_reg <= '0;
         im_din_reg  <= '0;
         im_en_reg   <= 1'b0;
      end else begin
         pe_en_reg <= cfg_fire & ~cfg_sel_in;
         im_en_reg <= cfg_fire & cfg_sel_in;
         if (cfg_fire && !cfg_sel_in) begin
            pe_addr_reg <= cfg_addr_in;
            pe_din_reg  <= cfg_data_in[CTX_PE_BITS-1:0];
         end
         if (cfg_fire && cfg_sel_in) begin
            im_addr_reg <= cfg_addr_in;
            im_din_reg  <= cfg_data_in[CTX_IM_BITS-1:0];
         end
      end
   end

   assign cfg_ready_out    = ready_reg;
   assign Mode_out         = mode_reg;
   assign CTX_PE_addra_out = pe_addr_reg;
   assign CTX_PE_dina_out  = pe_din_reg;
   assign CTX_PE_ena_out   = pe_en_reg;
   assign CTX_PE_wea_out   = pe_en_reg;
   assign CTX_IM_addra_out = im_addr_reg;
   assign CTX_IM_dina_out  = im_din_reg;
   assign CTX_IM_ena_out   = im_en_reg;
   assign CTX_IM_wea_out   = im_en_reg;

`ifdef CGRA_CTRL_PERF_EN
   logic [1:0]  perf_en;
   logic [31:0] perf_cnt [2];

   assign perf_en[0] = busy_out;
   assign perf_en[1] = (state_reg == ST_EXEC) & stall_in;

   for (genvar gi = 0; gi < 2; gi++) begin : g_perf
      cgra_perf_cnt u_perf_cnt (
         .CLK (CLK),
         .RST (RST),
         .clr (run_accept),
         .en  (perf_en[gi]),
         .cnt (perf_cnt[gi])
      );
   end

   assign cycle_cnt_out = perf_cnt[0];
   assign stall_cnt_out = perf_cnt[1];
`else
   assign cycle_cnt_out = 32'd0;
   assign stall_cnt_out = 32'd0;
`endif

endmodule
